addpipe_ctrl: RTL and testbench

Pipeline sequencer for the floating-point add pipeline (exponent compare -> align -> add -> normalize).
- Accepts operand pairs through a valid/ready handshake.
- Tracks per-stage occupancy and generates per-stage load enables for the datapath registers, with stall propagation and bubble collapsing.
- Tags each operation, delivers results in order with output backpressure, and supports a synchronous flush.

---
 rtl/addpipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_addpipe_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addpipe_ctrl.sv
// addpipe_ctrl: sequencer for the floating-point add pipeline
// (exponent compare -> align -> add -> normalize).
//
// The controller owns no datapath; it tracks which stages hold a live
// operation, generates the per-stage register load enables, tags every
// accepted operation with a wrapping sequence number and delivers results
// in order under output backpressure.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   flush      in   synchronous flush, drops every in-flight operation
//   in_valid   in   upstream presents an operand pair
//   in_ready   out  operand pair is accepted this cycle
//   in_tag     out  tag given to the operation accepted this cycle
//   stage_en   out  load enable for datapath stage register k
//   stage_vld  out  stage k holds a valid operation
//   out_valid  out  result valid at the last stage
//   out_ready  in   downstream accepts the result
//   out_tag    out  tag of the result at the last stage
//   inflight   out  number of operations in the pipeline
//   idle       out  inflight == 0
module addpipe_ctrl #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [TAG_W-1:0]  in_tag,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_vld,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  inflight,
  output logic              idle
);

  // Per-stage occupancy and tag, plus the tag for the next accepted op.
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0]             next_tag_q, next_tag_d;
  logic [CNT_W-1:0]             inflight_q, inflight_d;

  logic [STAGES-1:0] en;
  logic              accept;
  logic              out_hs;

  // A stage may load when it is empty or when the stage after it moves on.
  // The ripple runs from the output end back towards the input; a single
  // running carry keeps the chain free of combinational self-reference.
  always_comb begin
    logic carry;
    carry = out_ready;
    en    = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      carry = ~v_q[k] | carry;
      en[k] = carry;
    end
  end

  // Handshakes. Flush masks both sides so no transfer is counted in that cycle.
  always_comb begin
    in_ready  = en[0] & ~flush;
    accept    = in_valid & in_ready;
    out_valid = v_q[STAGES-1] & ~flush;
    out_hs    = out_valid & out_ready;
  end

  // Stage advance. An empty stage always has en=1, so bubbles collapse
  // even while stages further down are stalled.
  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    if (en[0]) begin
      v_d[0]   = accept;
      tag_d[0] = next_tag_q;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (en[k]) begin
        v_d[k]   = v_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    // Tags may still shift on flush; with every valid bit cleared they are dead.
    if (flush) begin
      v_d = '0;
    end
  end

  // Sequence tag wraps naturally; flush deliberately leaves it alone so tags
  // stay unique across a flush.
  always_comb begin
    next_tag_d = next_tag_q;
    if (accept) begin
      next_tag_d = next_tag_q + TAG_W'(1);
    end
  end

  // Occupancy count: simultaneous accept and output leave it unchanged.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, out_hs})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    if (flush) begin
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      v_q        <= '0;
      tag_q      <= '0;
      next_tag_q <= '0;
      inflight_q <= '0;
    end else begin
      v_q        <= v_d;
      tag_q      <= tag_d;
      next_tag_q <= next_tag_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    in_tag    = next_tag_q;
    stage_en  = en;
    stage_vld = v_q;
    out_tag   = tag_q[STAGES-1];
    inflight  = inflight_q;
    idle      = (inflight_q == '0);
  end

endmodule

// File: tb/tb_addpipe_ctrl.sv
// Bench for addpipe_ctrl: directed scenarios plus a tag scoreboard that
// records tags at accept and checks them at the output handshake.
module tb_addpipe_ctrl;

  localparam int unsigned STAGES = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk;
  logic              clr;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_vld;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [CNT_W-1:0]  inflight;
  logic              idle;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TAG_W-1:0] sb[$];
  logic [TAG_W-1:0] m_tag;
  int               m_inflight;
  logic [TAG_W-1:0] saved_tag;

  addpipe_ctrl #(
    .STAGES(STAGES),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tag   (in_tag),
    .stage_en (stage_en),
    .stage_vld(stage_vld),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tag  (out_tag),
    .inflight (inflight),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    step();
    step();
    clr = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40 && !idle; c++) step();
    check_eq(name, {31'd0, idle}, 32'd1);
    check_eq({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Scoreboard: inputs are stable from mid-cycle until the next rising edge,
  // so the handshakes seen here are the ones that edge will commit.
  always @(negedge clk) begin
    if (!clr) begin
      sb.delete();
      m_tag      = '0;
      m_inflight = 0;
    end else begin
      check_eq("inflight", inflight, m_inflight);
      check_eq("idle", {31'd0, idle}, {31'd0, (m_inflight == 0)});
      check_eq("in_tag", in_tag, m_tag);
      if (flush) begin
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        sb.delete();
        m_inflight = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("out_unexpected", {31'd0, out_valid}, 32'd0);
          end else begin
            check_eq("out_tag_order", out_tag, sb.pop_front());
            m_inflight--;
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back(m_tag);
          m_tag = m_tag + 1'b1;
          m_inflight++;
        end
      end
    end
  end

  initial begin
    clr       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_eq("rst_vld", stage_vld, 0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_idle", {31'd0, idle}, 1);
    check_eq("rst_inflight", inflight, 0);
    clr = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 1);
    check_eq("rst_in_tag", in_tag, 0);

    // Single op: stage k after edge k, output for exactly one cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("single_inflight", inflight, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check_eq("single_vld", stage_vld, 32'd1 << i);
      check_eq("single_out_valid", {31'd0, out_valid}, (i == 3) ? 1 : 0);
    end
    check_eq("single_out_tag", out_tag, 0);
    step();
    check_eq("single_out_valid_drop", {31'd0, out_valid}, 0);
    check_eq("single_idle", {31'd0, idle}, 1);

    // Streaming 18 ops from a fresh tag counter.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      step();
      if (i >= 3) begin
        check_eq("stream_out_valid", {31'd0, out_valid}, 1);
        check_eq("stream_out_tag", out_tag, (i - 3) % 16);
      end
      if (i >= 3 && i <= 17) check_eq("stream_inflight", inflight, 4);
      if (i == 17) in_valid = 1'b0;
    end
    drain("stream_drain");

    // Backpressure and bubble collapsing.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("bp_vld_a", stage_vld, 4'b0101);
    step();
    check_eq("bp_vld_b", stage_vld, 4'b1010);
    step();
    check_eq("bp_vld_c", stage_vld, 4'b1100);
    check_eq("bp_en_c", stage_en, 4'b0011);
    check_eq("bp_inflight_c", inflight, 2);
    in_valid = 1'b1;
    step();
    check_eq("bp_vld_d", stage_vld, 4'b1101);
    step();
    check_eq("bp_vld_full", stage_vld, 4'b1111);
    check_eq("bp_in_ready_full", {31'd0, in_ready}, 0);
    check_eq("bp_en_full", stage_en, 4'b0000);
    check_eq("bp_inflight_full", inflight, 4);
    step();
    check_eq("bp_vld_hold", stage_vld, 4'b1111);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_release", {31'd0, in_ready}, 1);
    check_eq("bp_en_release", stage_en, 4'b1111);
    step();
    in_valid = 1'b0;
    check_eq("bp_inflight_swap", inflight, 4);
    drain("bp_drain");

    // Flush with both handshakes requested.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 10 && in_ready; c++) step();
    check_eq("fl_full", stage_vld, 4'b1111);
    saved_tag = m_tag;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check_eq("fl_in_ready", {31'd0, in_ready}, 0);
    check_eq("fl_out_valid", {31'd0, out_valid}, 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("fl_vld", stage_vld, 0);
    check_eq("fl_inflight", inflight, 0);
    check_eq("fl_in_tag", in_tag, saved_tag);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain("fl_drain");

    // Asynchronous reset with three ops held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    step();
    step();
    in_valid = 1'b0;
    check_eq("mr_pre_inflight", inflight, 3);
    #2;
    clr = 1'b0;
    #1;
    check_eq("mr_vld", stage_vld, 0);
    check_eq("mr_out_valid", {31'd0, out_valid}, 0);
    check_eq("mr_inflight", inflight, 0);
    check_eq("mr_idle", {31'd0, idle}, 1);
    step();
    clr = 1'b1;
    #1;
    check_eq("mr_in_ready", {31'd0, in_ready}, 1);
    check_eq("mr_in_tag", in_tag, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
